// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the 4x4 / 7x7 SAD array.
package sad_pkg;
    localparam int BLK     = 4;
    localparam int RNG     = 4;
    localparam int WIN     = 7;
    localparam int N_CAND  = 16;
    localparam int CUR_PIX = 16;
    localparam int REF_PIX = 49;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_REF,
        CALC,
        DONE
    } sad_state_t;
endpackage

// File: rtl/sad_absdiff.sv
// Unsigned PIX_W-bit absolute difference |a - b|.
module sad_absdiff #(
    parameter int PIX_W = 8
) (
    input  logic [PIX_W-1:0] a_i,
    input  logic [PIX_W-1:0] b_i,
    output logic [PIX_W-1:0] diff_o
);
    assign diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
endmodule

// File: rtl/sad_array.sv
// Full-search SAD engine: loads a 4x4 block and 7x7 window, then sums 16 candidates in parallel.
// Optional macro SAD_REF_REUSE_EN lets a job keep the previous reference window.
module sad_array
    import sad_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int SUM_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             reuse_ref,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             busy,
    output logic             sum_valid,
    output logic [SUM_W-1:0] sum0,
    output logic [SUM_W-1:0] sum1,
    output logic [SUM_W-1:0] sum2,
    output logic [SUM_W-1:0] sum3,
    output logic [SUM_W-1:0] sum4,
    output logic [SUM_W-1:0] sum5,
    output logic [SUM_W-1:0] sum6,
    output logic [SUM_W-1:0] sum7,
    output logic [SUM_W-1:0] sum8,
    output logic [SUM_W-1:0] sum9,
    output logic [SUM_W-1:0] sum10,
    output logic [SUM_W-1:0] sum11,
    output logic [SUM_W-1:0] sum12,
    output logic [SUM_W-1:0] sum13,
    output logic [SUM_W-1:0] sum14,
    output logic [SUM_W-1:0] sum15
);
    sad_state_t       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             acc_clr;
    logic             skip_ref;
    logic [PIX_W-1:0] cur_q [CUR_PIX];
    logic [PIX_W-1:0] ref_q [REF_PIX];
    logic [SUM_W-1:0] acc_q [N_CAND];
    logic [PIX_W-1:0] cur_pix;
    logic [5:0]       ref_idx [N_CAND];
    logic [PIX_W-1:0] ad [N_CAND];

`ifdef SAD_REF_REUSE_EN
    logic reuse_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reuse_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            reuse_q <= reuse_ref;
        end
    end
    assign skip_ref = reuse_q;
`else
    logic unused_reuse;
    assign unused_reuse = reuse_ref;
    assign skip_ref     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pix_ready = 1'b0;
        busy      = 1'b1;
        sum_valid = 1'b0;
        acc_clr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD_CUR;
            end
            LOAD_CUR: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    if (cnt_q == 6'(CUR_PIX - 1)) begin
                        cnt_d   = '0;
                        acc_clr = skip_ref;
                        state_d = skip_ref ? CALC : LOAD_REF;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            LOAD_REF: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    if (cnt_q == 6'(REF_PIX - 1)) begin
                        cnt_d   = '0;
                        acc_clr = 1'b1;
                        state_d = CALC;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            CALC: begin
                if (cnt_q == 6'(N_CAND - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                sum_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel stores are never reset; a new load simply overwrites them.
    always_ff @(posedge clk) begin
        if (pix_valid && state_q == LOAD_CUR) cur_q[cnt_q[3:0]] <= pix_in;
        if (pix_valid && state_q == LOAD_REF) ref_q[cnt_q]      <= pix_in;
    end

    // In CALC, cnt_q[3:2] is the block row r and cnt_q[1:0] the column c.
    assign cur_pix = cur_q[cnt_q[3:0]];

    for (genvar n = 0; n < N_CAND; n++) begin : g_cand
        localparam logic [5:0] DY = 6'(n / RNG);
        localparam logic [5:0] DX = 6'(n % RNG);
        logic [5:0] row, col;
        assign row        = {4'b0, cnt_q[3:2]} + DY;
        assign col        = {4'b0, cnt_q[1:0]} + DX;
        assign ref_idx[n] = row * 6'(WIN) + col;
        sad_absdiff #(.PIX_W(PIX_W)) u_absdiff (
            .a_i    (cur_pix),
            .b_i    (ref_q[ref_idx[n]]),
            .diff_o (ad[n])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int n = 0; n < N_CAND; n++) acc_q[n] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int n = 0; n < N_CAND; n++) begin
                if (acc_clr) begin
                    acc_q[n] <= '0;
                end else if (state_q == CALC) begin
                    acc_q[n] <= acc_q[n] + {{(SUM_W - PIX_W){1'b0}}, ad[n]};
                end
            end
        end
    end

    assign sum0  = acc_q[0];
    assign sum1  = acc_q[1];
    assign sum2  = acc_q[2];
    assign sum3  = acc_q[3];
    assign sum4  = acc_q[4];
    assign sum5  = acc_q[5];
    assign sum6  = acc_q[6];
    assign sum7  = acc_q[7];
    assign sum8  = acc_q[8];
    assign sum9  = acc_q[9];
    assign sum10 = acc_q[10];
    assign sum11 = acc_q[11];
    assign sum12 = acc_q[12];
    assign sum13 = acc_q[13];
    assign sum14 = acc_q[14];
    assign sum15 = acc_q[15];
endmodule
